// File: rtl/cdb_broadcast_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_broadcast_arbiter
//
// Common-data-bus arbiter and broadcaster for the Tomasulo core. Up to
// NUM_UNITS producer channels offer completed results with a valid/ready
// handshake. One channel is granted per cycle by round-robin, and the winner
// is registered onto the CDB (tag, destination, data) together with the FP
// register-file write port.
//
// Optional feature (compile-time macro): CDB_CONFLICT_STATS_EN
//   defined     -> conflict_cnt counts cycles in which a valid channel was
//                  not granted. The counter saturates at 16'hFFFF.
//   not defined -> conflict_cnt is tied to zero and no counter is built.
//
// Ports
//   clock          system clock; all state changes on the rising edge
//   reset          synchronous, active-high
//   fu_valid[i]    channel i holds a completed result
//   fu_ready[i]    one-hot grant; a transfer occurs on fu_valid & fu_ready
//   fu_tag         per-channel RS tag,           channel i at [i*TAG_W +: TAG_W]
//   fu_dest        per-channel destination reg,  channel i at [i*REG_AW +: REG_AW]
//   fu_data        per-channel result value,     channel i at [i*DATA_W +: DATA_W]
//   fu_wb[i]       1 = write the register file, 0 = broadcast only (store ack)
//   cdb_stall      downstream hold; no grant is made while high
//   cdb_valid      one-cycle broadcast pulse per accepted result
//   cdb_tag/dest/data  broadcast fields; they hold between broadcasts
//   rf_we/addr/data    register-file write port
//   conflict_cnt   arbitration-loss counter (zero unless stats are enabled)
// ---------------------------------------------------------------------------
module cdb_broadcast_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int DATA_W    = 16,
    parameter int REG_AW    = 3,
    parameter int TAG_W     = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_UNITS-1:0]        fu_valid,
    output logic [NUM_UNITS-1:0]        fu_ready,
    input  logic [NUM_UNITS*TAG_W-1:0]  fu_tag,
    input  logic [NUM_UNITS*REG_AW-1:0] fu_dest,
    input  logic [NUM_UNITS*DATA_W-1:0] fu_data,
    input  logic [NUM_UNITS-1:0]        fu_wb,
    input  logic                        cdb_stall,
    output logic                        cdb_valid,
    output logic [TAG_W-1:0]            cdb_tag,
    output logic [REG_AW-1:0]           cdb_dest,
    output logic [DATA_W-1:0]           cdb_data,
    output logic                        rf_we,
    output logic [REG_AW-1:0]           rf_addr,
    output logic [DATA_W-1:0]           rf_data,
    output logic [15:0]                 conflict_cnt
);

    localparam int PTR_W = $clog2(NUM_UNITS);

    logic [PTR_W-1:0]     rrPtr;      // last channel granted
    logic [NUM_UNITS-1:0] grant;
    logic [PTR_W-1:0]     grantIdx;
    logic                 transfer;
    logic [TAG_W-1:0]     selTag;
    logic [REG_AW-1:0]    selDest;
    logic [DATA_W-1:0]    selData;
    logic                 selWb;

    // Channel index 'offset' positions after 'base', wrapping at NUM_UNITS
    // (NUM_UNITS need not be a power of two).
    function automatic logic [PTR_W-1:0] wrapIdx(input logic [PTR_W-1:0] base,
                                                  input int offset);
        return PTR_W'((int'(base) + offset) % NUM_UNITS);
    endfunction

    // Round-robin search starting one past the last winner. Because grant
    // is only ever set where fu_valid is high, |grant is the transfer strobe.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise paths that skip an assignment infer latches.
        grant    = '0;
        grantIdx = '0;
        if (!reset && !cdb_stall) begin
            for (int off = 1; off <= NUM_UNITS; off++) begin
                if (grant == '0 && fu_valid[wrapIdx(rrPtr, off)]) begin
                    grant[wrapIdx(rrPtr, off)] = 1'b1;
                    grantIdx                   = wrapIdx(rrPtr, off);
                end
            end
        end
    end

    assign fu_ready = grant;
    assign transfer = |grant;

    // One-hot mux of the granted channel's fields (constant-index slices).
    always_comb begin
        selTag  = '0;
        selDest = '0;
        selData = '0;
        selWb   = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (grant[i]) begin
                selTag  = fu_tag[i*TAG_W +: TAG_W];
                selDest = fu_dest[i*REG_AW +: REG_AW];
                selData = fu_data[i*DATA_W +: DATA_W];
                selWb   = fu_wb[i];
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            rrPtr     <= PTR_W'(NUM_UNITS - 1);   // channel 0 wins first
            cdb_valid <= 1'b0;
            rf_we     <= 1'b0;
            cdb_tag   <= '0;
            cdb_dest  <= '0;
            cdb_data  <= '0;
        end else begin
            cdb_valid <= transfer;
            rf_we     <= transfer & selWb;
            if (transfer) begin
                rrPtr    <= grantIdx;
                cdb_tag  <= selTag;
                cdb_dest <= selDest;
                cdb_data <= selData;
            end
        end
    end

    // The register-file port always carries the broadcast destination and
    // data; only the write enable distinguishes stores from writebacks.
    assign rf_addr = cdb_dest;
    assign rf_data = cdb_data;

`ifdef CDB_CONFLICT_STATS_EN
    logic [15:0] conflictCnt;

    // Counts any cycle with a valid-but-ungranted channel, stalls included.
    always_ff @(posedge clock) begin
        if (reset) begin
            conflictCnt <= '0;
        end else if (|(fu_valid & ~grant) && conflictCnt != 16'hFFFF) begin
            conflictCnt <= conflictCnt + 16'd1;
        end
    end

    assign conflict_cnt = conflictCnt;
`else
    assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for cdb_broadcast_arbiter (default parameters, NUM_UNITS = 4).
// Directed stimulus with hand-computed grants; each expected grant pushes the
// expected broadcast into a queue, and an independent monitor pops and
// compares it whenever the DUT presents cdb_valid.
// ---------------------------------------------------------------------------
module tb_cdb_broadcast_arbiter;

    localparam int NU = 4;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int TW = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic [NU-1:0]    fu_valid;
    logic [NU-1:0]    fu_ready;
    logic [NU*TW-1:0] fu_tag;
    logic [NU*AW-1:0] fu_dest;
    logic [NU*DW-1:0] fu_data;
    logic [NU-1:0]    fu_wb;
    logic             cdb_stall;
    logic             cdb_valid;
    logic [TW-1:0]    cdb_tag;
    logic [AW-1:0]    cdb_dest;
    logic [DW-1:0]    cdb_data;
    logic             rf_we;
    logic [AW-1:0]    rf_addr;
    logic [DW-1:0]    rf_data;
    logic [15:0]      conflict_cnt;

    cdb_broadcast_arbiter #(
        .NUM_UNITS(NU), .DATA_W(DW), .REG_AW(AW), .TAG_W(TW)
    ) dut (
        .clock(clock), .reset(reset),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_tag(fu_tag), .fu_dest(fu_dest), .fu_data(fu_data), .fu_wb(fu_wb),
        .cdb_stall(cdb_stall),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_dest(cdb_dest),
        .cdb_data(cdb_data),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clock = ~clock;

    // Per-channel stimulus fields, packed onto the DUT buses.
    logic [TW-1:0] chTag  [NU];
    logic [AW-1:0] chDest [NU];
    logic [DW-1:0] chData [NU];
    logic [NU-1:0] chWb;

    always_comb begin
        fu_tag  = '0;
        fu_dest = '0;
        fu_data = '0;
        for (int i = 0; i < NU; i++) begin
            fu_tag[i*TW +: TW]  = chTag[i];
            fu_dest[i*AW +: AW] = chDest[i];
            fu_data[i*DW +: DW] = chData[i];
        end
    end
    assign fu_wb = chWb;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
        logic          we;
    } bcast_t;

    bcast_t expQ[$];
    bcast_t monItem;
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic setChan(input int ch, input logic [TW-1:0] t,
                           input logic [AW-1:0] d, input logic [DW-1:0] v,
                           input logic wb);
        chTag[ch]  = t;
        chDest[ch] = d;
        chData[ch] = v;
        chWb[ch]   = wb;
    endtask

    // Inputs change 1 time unit after each rising edge.
    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Checks the combinational grant; a non-zero grant queues the broadcast
    // expected from channel ch on the following cycle.
    task automatic expectReady(input string name, input logic [NU-1:0] exp,
                               input int ch);
        bcast_t item;
        #1;
        check(name, 32'(fu_ready), 32'(exp));
        if (exp != '0) begin
            item.tag  = chTag[ch];
            item.dest = chDest[ch];
            item.data = chData[ch];
            item.we   = chWb[ch];
            expQ.push_back(item);
        end
    endtask

    // Monitor: compares every broadcast against the queue head.
    initial begin
        forever begin
            @(posedge clock);
            #3;
            if (cdb_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    check("cdb_valid_unexpected", 32'(cdb_valid), 32'd0);
                end else begin
                    monItem = expQ.pop_front();
                    check("cdb_tag",  32'(cdb_tag),  32'(monItem.tag));
                    check("cdb_dest", 32'(cdb_dest), 32'(monItem.dest));
                    check("cdb_data", 32'(cdb_data), 32'(monItem.data));
                    check("rf_we",    32'(rf_we),    32'(monItem.we));
                    check("rf_addr",  32'(rf_addr),  32'(monItem.dest));
                    check("rf_data",  32'(rf_data),  32'(monItem.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cdb_stall = 1'b0;
        fu_valid  = '0;
        for (int i = 0; i < NU; i++) setChan(i, '0, '0, '0, 1'b0);

        // ---- Reset state ----
        step; step;
        check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        check("rst_rf_we",     32'(rf_we),     32'd0);
        check("rst_cdb_tag",   32'(cdb_tag),   32'd0);
        check("rst_cdb_dest",  32'(cdb_dest),  32'd0);
        check("rst_cdb_data",  32'(cdb_data),  32'd0);
        check("rst_rf_addr",   32'(rf_addr),   32'd0);
        check("rst_rf_data",   32'(rf_data),   32'd0);
        check("rst_conflict",  32'(conflict_cnt), 32'd0);
        fu_valid = 4'hF;
        expectReady("ready_in_reset", 4'b0000, 0);

        // ---- Round-robin: all channels valid from reset ----
        step;
        reset = 1'b0;
        setChan(0, 3'd1, 3'd1, 16'h1111, 1'b1);
        setChan(1, 3'd2, 3'd2, 16'h2222, 1'b1);
        setChan(2, 3'd3, 3'd4, 16'h3333, 1'b1);
        setChan(3, 3'd4, 3'd7, 16'h4444, 1'b0);
        expectReady("rr_grant_0", 4'b0001, 0);
        step; expectReady("rr_grant_1", 4'b0010, 1);
        step; expectReady("rr_grant_2", 4'b0100, 2);
        step; expectReady("rr_grant_3", 4'b1000, 3);
        step; expectReady("rr_grant_0b", 4'b0001, 0);
        step;
`ifdef CDB_CONFLICT_STATS_EN
        check("rr_conflict_cnt", 32'(conflict_cnt), 32'd5);
`else
        check("rr_conflict_cnt", 32'(conflict_cnt), 32'd0);
`endif
        fu_valid = '0;
        expectReady("rr_idle", 4'b0000, 0);

        // ---- Single result on channel 2 (rr_ptr = 0) ----
        step;
        setChan(2, 3'd5, 3'd3, 16'h1234, 1'b1);
        fu_valid = 4'b0100;
        expectReady("single_grant", 4'b0100, 2);
        step;
        fu_valid = '0;
        expectReady("single_idle", 4'b0000, 0);
        step;
        check("single_pulse_end_valid", 32'(cdb_valid), 32'd0);
        check("single_pulse_end_we",    32'(rf_we),     32'd0);
        check("single_hold_tag",        32'(cdb_tag),   32'd5);
        check("single_hold_addr",       32'(rf_addr),   32'd3);

        // ---- Store broadcast on channel 1 (rr_ptr = 2) ----
        setChan(1, 3'd6, 3'd2, 16'h00AC, 1'b0);
        fu_valid = 4'b0010;
        expectReady("store_grant", 4'b0010, 1);
        step;
        fu_valid = '0;
        expectReady("store_idle", 4'b0000, 0);
        step;

        // ---- Reset mid-operation (rr_ptr = 1, so channel 0 wins) ----
        setChan(0, 3'd1, 3'd5, 16'h0F0F, 1'b1);
        setChan(1, 3'd2, 3'd6, 16'hBEEF, 1'b1);
        fu_valid = 4'b0011;
        expectReady("pre_reset_grant", 4'b0001, 0);
        step;
        reset = 1'b1;
        expectReady("ready_in_midreset", 4'b0000, 0);

        // ---- Stall straight after reset: channels 0 and 3 valid ----
        step;
        reset     = 1'b0;
        cdb_stall = 1'b1;
        setChan(3, 3'd7, 3'd4, 16'h5A5A, 1'b1);
        fu_valid = 4'b1001;
        check("reset_drop_valid", 32'(cdb_valid), 32'd0);
        check("reset_drop_we",    32'(rf_we),     32'd0);
        check("reset_clear_tag",  32'(cdb_tag),   32'd0);
        expectReady("stall_1", 4'b0000, 0);
        step;
        check("stall_2_cdb_valid", 32'(cdb_valid), 32'd0);
        expectReady("stall_2", 4'b0000, 0);
        step;
        check("stall_3_cdb_valid", 32'(cdb_valid), 32'd0);
        expectReady("stall_3", 4'b0000, 0);
        step;
        check("stall_end_cdb_valid", 32'(cdb_valid), 32'd0);
        cdb_stall = 1'b0;
        expectReady("post_stall_ch0", 4'b0001, 0);
        step;
        fu_valid = 4'b1000;
        expectReady("post_stall_ch3", 4'b1000, 3);
        step;
        fu_valid = '0;
        expectReady("post_stall_idle", 4'b0000, 0);
        step;
`ifdef CDB_CONFLICT_STATS_EN
        check("stall_conflict_cnt", 32'(conflict_cnt), 32'd4);
`else
        check("stall_conflict_cnt", 32'(conflict_cnt), 32'd0);
`endif

        // ---- Saturation: two channels valid under stall ----
`ifdef CDB_CONFLICT_STATS_EN
        force dut.conflictCnt = 16'hFFFE;
        #1;
        release dut.conflictCnt;
`endif
        cdb_stall = 1'b1;
        fu_valid  = 4'b0011;
        expectReady("sat_stall_ready", 4'b0000, 0);
        step;
`ifdef CDB_CONFLICT_STATS_EN
        check("sat_reach", 32'(conflict_cnt), 32'hFFFF);
`else
        check("sat_reach", 32'(conflict_cnt), 32'h0);
`endif
        step;
`ifdef CDB_CONFLICT_STATS_EN
        check("sat_hold", 32'(conflict_cnt), 32'hFFFF);
`else
        check("sat_hold", 32'(conflict_cnt), 32'h0);
`endif
        fu_valid  = '0;
        cdb_stall = 1'b0;
        step; step;

        check("queue_drained", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
